// File: rtl/bird_pkg.sv
// Shared types and constants for the bird launch scheduler.
package bird_pkg;

    typedef enum logic [1:0] {
        READY_ST,
        SELECT_ST,
        LAUNCH_ST,
        COOLDOWN_ST
    } launch_state_t;

    localparam int unsigned SCREEN_HALF_X = 288;
    localparam int unsigned AMMO_W        = 4;
    localparam int unsigned X_W           = 11;
    localparam int unsigned CNT_W         = 8;

    // Population count of up to eight slot flags.
    function automatic logic [AMMO_W-1:0] popcount8(input logic [7:0] v);
        logic [AMMO_W-1:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + AMMO_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rr_free_picker.sv
// Combinational round-robin search for the first free slot at or above rrPtr.
module rr_free_picker #(
    parameter  int unsigned NUM_BIRDS = 4,
    localparam int unsigned IDX_W     = $clog2(NUM_BIRDS)
) (
    input  logic [NUM_BIRDS-1:0] busy,
    input  logic [IDX_W-1:0]     rrPtr,
    output logic [NUM_BIRDS-1:0] grant,
    output logic [IDX_W-1:0]     index,
    output logic                 anyFree
);

    always_comb begin
        logic        found;
        int unsigned idx;
        grant   = '0;
        index   = '0;
        found   = 1'b0;
        idx     = 0;
        anyFree = ~&busy;
        for (int unsigned off = 0; off < NUM_BIRDS; off++) begin
            idx = 32'(rrPtr) + off;
            if (idx >= NUM_BIRDS) begin
                idx = idx - NUM_BIRDS;
            end
            if (!found && !busy[IDX_W'(idx)]) begin
                found               = 1'b1;
                grant[IDX_W'(idx)]  = 1'b1;
                index               = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bird_launch_ctrl.sv
// Launch scheduler: latches drop requests, checks ammo/cooldown/plane position,
// hands a free bird_move slot a showBird command and tracks busy slots.
module bird_launch_ctrl
    import bird_pkg::*;
#(
    parameter int unsigned NUM_BIRDS          = 4,
    parameter int unsigned COOLDOWN_FRAMES    = 15,
    parameter int unsigned MAX_AMMO           = 8,
    parameter int unsigned X_LAUNCH_LIMIT     = SCREEN_HALF_X,
    parameter int unsigned ACK_TIMEOUT_FRAMES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startOfFrame,
    input  logic                 dropReq,
    input  logic                 refill,
    input  logic [X_W-1:0]       planeTopLeftX,
    input  logic [NUM_BIRDS-1:0] displayBird,
    input  logic [NUM_BIRDS-1:0] hideBirdPulse,
    output logic [NUM_BIRDS-1:0] showBird,
    output logic                 launchPulse,
    output logic                 noAmmoPulse,
    output logic [AMMO_W-1:0]    ammo,
    output logic [AMMO_W-1:0]    activeCount,
    output logic                 coolingDown
);

    localparam int unsigned      IDX_W     = $clog2(NUM_BIRDS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BIRDS - 1);
    localparam logic [AMMO_W-1:0] AMMO_FULL = AMMO_W'(MAX_AMMO);
    localparam logic [CNT_W-1:0] COOL_INIT = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT_FRAMES - 1);
    localparam logic [X_W-1:0]   X_LIMIT   = X_W'(X_LAUNCH_LIMIT);

    launch_state_t          state_q, state_d;
    logic [NUM_BIRDS-1:0]   busy_q, busy_d;
    logic [AMMO_W-1:0]      ammo_q, ammo_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       slot_q, slot_d;
    logic                   drop_pending_q, drop_pending_d;
    logic                   drop_req_q;
    logic [NUM_BIRDS-1:0]   display_q;
    logic [CNT_W-1:0]       cool_cnt_q, cool_cnt_d;
    logic [CNT_W-1:0]       ack_cnt_q, ack_cnt_d;
    logic [NUM_BIRDS-1:0]   show_bird_q, show_bird_d;
    logic                   launch_pulse_q, launch_pulse_d;
    logic                   no_ammo_pulse_q, no_ammo_pulse_d;
    logic [AMMO_W-1:0]      active_count_q, active_count_d;
    logic                   cooling_down_q, cooling_down_d;

    logic [NUM_BIRDS-1:0]   pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any_free;
    logic                   drop_edge;
    logic                   ack_edge;
    logic                   x_too_far;

    rr_free_picker #(
        .NUM_BIRDS (NUM_BIRDS)
    ) u_picker (
        .busy    (busy_q),
        .rrPtr   (rr_ptr_q),
        .grant   (pick_grant),
        .index   (pick_idx),
        .anyFree (pick_any_free)
    );

    assign drop_edge = dropReq & ~drop_req_q;
    assign ack_edge  = displayBird[slot_q] & ~display_q[slot_q];
    assign x_too_far = planeTopLeftX > X_LIMIT;

    // Next-state, slot bookkeeping and registered-output computation.
    always_comb begin
        state_d         = state_q;
        busy_d          = busy_q & ~hideBirdPulse;
        ammo_d          = ammo_q;
        rr_ptr_d        = rr_ptr_q;
        slot_d          = slot_q;
        drop_pending_d  = drop_pending_q;
        cool_cnt_d      = cool_cnt_q;
        ack_cnt_d       = ack_cnt_q;
        show_bird_d     = show_bird_q;
        launch_pulse_d  = 1'b0;
        no_ammo_pulse_d = 1'b0;

        unique case (state_q)
            READY_ST: begin
                if (startOfFrame && drop_pending_q) begin
                    if (ammo_q == '0) begin
                        drop_pending_d  = 1'b0;
                        no_ammo_pulse_d = 1'b1;
                    end else if (pick_any_free && !x_too_far) begin
                        state_d = SELECT_ST;
                    end
                end
                // An edge arriving with the evaluating frame waits for the next one.
                if (drop_edge) begin
                    drop_pending_d = 1'b1;
                end
            end
            SELECT_ST: begin
                slot_d         = pick_idx;
                rr_ptr_d       = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
                busy_d         = busy_d | pick_grant;
                ammo_d         = ammo_q - 1'b1;
                drop_pending_d = 1'b0;
                ack_cnt_d      = '0;
                show_bird_d    = pick_grant;
                state_d        = LAUNCH_ST;
            end
            LAUNCH_ST: begin
                if (ack_edge) begin
                    show_bird_d    = '0;
                    launch_pulse_d = 1'b1;
                    cool_cnt_d     = COOL_INIT;
                    state_d        = COOLDOWN_ST;
                end else if (startOfFrame) begin
                    if (ack_cnt_q >= ACK_LAST) begin
                        show_bird_d    = '0;
                        busy_d[slot_q] = 1'b0;
                        ammo_d         = (ammo_q < AMMO_FULL) ? ammo_q + 1'b1 : ammo_q;
                        state_d        = READY_ST;
                    end else begin
                        ack_cnt_d = ack_cnt_q + 1'b1;
                    end
                end
            end
            COOLDOWN_ST: begin
                if (cool_cnt_q == '0) begin
                    state_d = READY_ST;
                end else if (startOfFrame) begin
                    cool_cnt_d = cool_cnt_q - 1'b1;
                end
                if (drop_edge) begin
                    drop_pending_d = 1'b1;
                end
            end
        endcase

        if (refill) begin
            ammo_d = AMMO_FULL;
        end

        active_count_d = popcount8(8'(busy_q));
        cooling_down_d = (state_d == COOLDOWN_ST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= READY_ST;
            busy_q          <= '0;
            ammo_q          <= AMMO_FULL;
            rr_ptr_q        <= '0;
            slot_q          <= '0;
            drop_pending_q  <= 1'b0;
            drop_req_q      <= 1'b0;
            display_q       <= '0;
            cool_cnt_q      <= '0;
            ack_cnt_q       <= '0;
            show_bird_q     <= '0;
            launch_pulse_q  <= 1'b0;
            no_ammo_pulse_q <= 1'b0;
            active_count_q  <= '0;
            cooling_down_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            busy_q          <= busy_d;
            ammo_q          <= ammo_d;
            rr_ptr_q        <= rr_ptr_d;
            slot_q          <= slot_d;
            drop_pending_q  <= drop_pending_d;
            drop_req_q      <= dropReq;
            display_q       <= displayBird;
            cool_cnt_q      <= cool_cnt_d;
            ack_cnt_q       <= ack_cnt_d;
            show_bird_q     <= show_bird_d;
            launch_pulse_q  <= launch_pulse_d;
            no_ammo_pulse_q <= no_ammo_pulse_d;
            active_count_q  <= active_count_d;
            cooling_down_q  <= cooling_down_d;
        end
    end

    assign showBird    = show_bird_q;
    assign launchPulse = launch_pulse_q;
    assign noAmmoPulse = no_ammo_pulse_q;
    assign ammo        = ammo_q;
    assign activeCount = active_count_q;
    assign coolingDown = cooling_down_q;

endmodule

// File: doc/bird_launch_ctrl.md
Name: bird_launch_ctrl

Overview:
- Scheduler for a pool of NUM_BIRDS bird_move trajectory engines.
- Latches player drop requests, checks ammo, cooldown and plane position, picks a free bird slot round-robin, and drives that slot's showBird until the engine confirms with displayBird.
- Frees a slot when the engine returns its hideBirdPulse.
- Sits between the keypad/game manager and the bird_move instances.

Parameters:
- NUM_BIRDS, 4: number of bird_move slots (2..8).
- COOLDOWN_FRAMES, 15: frames between a confirmed launch and the next allowed launch.
- MAX_AMMO, 8: ammo count after reset or refill (1..15).
- X_LAUNCH_LIMIT, 288: launch allowed only while planeTopLeftX <= this value (pixels).
- ACK_TIMEOUT_FRAMES, 2: frames to wait for displayBird before aborting a launch.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-clock pulse per frame
- dropReq  in  1  player drop request, level; edge-detected internally
- refill  in  1  one-clock pulse, ammo := MAX_AMMO
- planeTopLeftX  in  11  plane position in pixels, unsigned
- displayBird  in  NUM_BIRDS  per-slot engine status
- hideBirdPulse  in  NUM_BIRDS  per-slot one-clock return pulse
- showBird  out  NUM_BIRDS  one-hot launch command
- launchPulse  out  1  one clock on confirmed launch
- noAmmoPulse  out  1  one clock when a request is rejected for zero ammo
- ammo  out  4  remaining ammo
- activeCount  out  4  number of busy slots
- coolingDown  out  1  high while in COOLDOWN_ST

Behaviour:
Reset (synchronous, reset=1 at a clk edge):
- State := READY_ST, busy := 0, ammo := MAX_AMMO, rrPtr := 0.
- dropPending := 0, dropReq edge register := 0, counters := 0.
- All outputs 0 except ammo = MAX_AMMO.
- Reset asserted mid-launch drops showBird on the next edge. No refund.

Request latch:
- Rising edge of dropReq sets dropPending in every state except SELECT_ST and LAUNCH_ST. Edges in those two states are ignored.
- Repeated edges do not queue; dropPending is a single bit.

Slot tracking:
- busy[i] is set on entry to LAUNCH_ST for the chosen slot.
- busy[i] is cleared on hideBirdPulse[i].
- hideBirdPulse on a non-busy slot is ignored.
- activeCount = popcount(busy), registered, updated the cycle after busy changes.

States:
- READY_ST: on startOfFrame with dropPending:
  - If ammo == 0: clear dropPending, pulse noAmmoPulse, stay in READY_ST.
  - Else if busy is all ones, or planeTopLeftX > X_LAUNCH_LIMIT: keep dropPending, stay in READY_ST.
  - Else: go to SELECT_ST.
  - With no startOfFrame, nothing is evaluated.
- SELECT_ST (1 clock):
  - Choose the first i with busy[i] == 0, searching from rrPtr upward with wrap.
  - slot := i, rrPtr := (i+1) mod NUM_BIRDS, busy[i] := 1, ammo := ammo-1, clear dropPending.
  - Go to LAUNCH_ST.
- LAUNCH_ST:
  - showBird[slot] = 1; all other showBird bits are 0.
  - Rising edge of displayBird[slot] ends the launch: showBird := 0, launchPulse 1 clock, cooldown counter := COOLDOWN_FRAMES, go to COOLDOWN_ST.
  - The launch aborts if ACK_TIMEOUT_FRAMES startOfFrame pulses pass without that edge. On abort: showBird := 0, busy[slot] := 0, ammo := ammo+1 (saturating at MAX_AMMO), no launchPulse, go to READY_ST.
- COOLDOWN_ST:
  - Counter decrements on each startOfFrame.
  - When the counter reaches 0, go to READY_ST on the next clock.
  - COOLDOWN_FRAMES = 0 gives one clock in COOLDOWN_ST.

Simultaneous events:
- refill in the same cycle as the SELECT decrement, or as an abort refund: refill wins, ammo = MAX_AMMO.
- hideBirdPulse on another slot during SELECT_ST: both updates apply. The freed slot is not considered until the next selection.
- startOfFrame and a dropReq edge in the same cycle in READY_ST: the edge is latched this cycle and evaluated at the next startOfFrame.

Latency:
- Qualifying startOfFrame -> showBird high: 2 clocks.
- The engine samples showBird at the following startOfFrame, so confirmation arrives about 1 frame later.

Decomposition:
- Package bird_pkg:
  - Enum type launch_state_t {READY_ST, SELECT_ST, LAUNCH_ST, COOLDOWN_ST}.
  - Constants SCREEN_HALF_X = 288 and AMMO_W = 4.
- Sub-module rr_free_picker: combinational round-robin first-free finder.
  - Inputs: busy, rrPtr.
  - Outputs: one-hot grant, index, anyFree.
  - Instantiated once.
- The FSM, counters and latches live in the top module.

Test Plan:
1. After reset, dropReq edge, planeTopLeftX=100, then startOfFrame -> showBird=4'b0001 2 clocks later; displayBird[0] rises -> launchPulse for 1 clock, ammo=7, activeCount=1, coolingDown=1 for 15 frames.
2. Four launches with no hides -> slots 0,1,2,3 in order, activeCount=4. A fifth request stays pending. hideBirdPulse[2] -> next launch uses slot 2, ammo=3.
3. planeTopLeftX=300 with a request pending -> no launch across 5 frames. Set X=288 -> launch at the next startOfFrame.
4. Eight confirmed launches with hides in between, then a request -> noAmmoPulse, ammo=0, no showBird. refill -> ammo=8, the next request launches.
5. Hold displayBird low in LAUNCH_ST for 2 startOfFrame pulses -> showBird=0, busy slot released, ammo restored, back to READY_ST, no launchPulse.
6. Assert reset while showBird=4'b0010 -> next edge: showBird=0, ammo=8, activeCount=0, state READY_ST.
